// File: rtl/urna_pkg.sv
// Shared ballot-box constants: candidate codes, 7-seg patterns and the voter-side FSM states.
package urna_pkg;

    localparam int unsigned CAND_A = 13;
    localparam int unsigned CAND_B = 22;

    // Active-low, bit order gfedcba
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DIGIT [10] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000   // 9
    };

    typedef enum logic [2:0] {
        StIdle,
        StOne,
        StTwo,
        StLock,
        StClosed
    } vote_state_e;

endpackage

// File: rtl/seg7_digit.sv
// Combinational digit to active-low 7-seg decoder; blank when not shown or not a decimal digit.
module seg7_digit
    import urna_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       show_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (show_i && (digit_i <= 4'd9)) begin
            seg_o = SEG_DIGIT[digit_i];
        end
    end

endmodule

// File: rtl/vote_capture.sv
// Voter-side front end: two-digit keypad entry, entry displays, and saturating vote tallies.
module vote_capture
    import urna_pkg::*;
#(
    parameter int unsigned LOCK_CYCLES = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clock,
    input  logic             start,
    input  logic             key_valid,
    input  logic [3:0]       key_digit,
    input  logic             confirm,
    input  logic             correct,
    input  logic             close_poll,
    output logic [6:0]       entry_disp1,
    output logic [6:0]       entry_disp2,
    output logic [CNT_W-1:0] c1,
    output logic [CNT_W-1:0] c2,
    output logic [CNT_W-1:0] nulo,
    output logic             vote_ack,
    output logic             finish
);

    localparam int unsigned LockW = $clog2(LOCK_CYCLES + 1);
    localparam logic [CNT_W-1:0] CntMax = '1;

    vote_state_e      state_q, state_d;
    logic [3:0]       d1_q, d1_d, d2_q, d2_d;
    logic [LockW-1:0] lock_q, lock_d;
    logic [CNT_W-1:0] c1_q, c1_d, c2_q, c2_d, nulo_q, nulo_d;
    logic             ack_q, commit;
    logic             key_ok;
    logic [6:0]       code;

    assign key_ok = key_valid && (key_digit <= 4'd9);
    assign code   = 7'(d1_q) * 7'd10 + 7'(d2_q);

    always_comb begin
        state_d = state_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        lock_d  = lock_q;
        commit  = 1'b0;
        if (close_poll && (state_q != StClosed)) begin
            state_d = StClosed;
            lock_d  = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (key_ok) begin
                        d1_d    = key_digit;
                        state_d = StOne;
                    end
                end
                StOne: begin
                    if (correct) begin
                        state_d = StIdle;
                    end else if (key_ok) begin
                        d2_d    = key_digit;
                        state_d = StTwo;
                    end
                end
                StTwo: begin
                    if (correct) begin
                        state_d = StIdle;
                    end else if (confirm) begin
                        commit  = 1'b1;
                        state_d = StLock;
                        lock_d  = LockW'(LOCK_CYCLES);
                    end
                end
                StLock: begin
                    // Leave on the cycle the count reaches zero, so LOCK lasts LOCK_CYCLES cycles
                    lock_d = lock_q - 1'b1;
                    if (lock_q <= LockW'(1)) begin
                        lock_d  = '0;
                        state_d = StIdle;
                    end
                end
                StClosed: begin
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        c1_d   = c1_q;
        c2_d   = c2_q;
        nulo_d = nulo_q;
        if (commit) begin
            if (code == 7'(CAND_A)) begin
                if (c1_q != CntMax) c1_d = c1_q + 1'b1;
            end else if (code == 7'(CAND_B)) begin
                if (c2_q != CntMax) c2_d = c2_q + 1'b1;
            end else begin
                if (nulo_q != CntMax) nulo_d = nulo_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (start) begin
            state_q <= StIdle;
            d1_q    <= '0;
            d2_q    <= '0;
            lock_q  <= '0;
            c1_q    <= '0;
            c2_q    <= '0;
            nulo_q  <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            lock_q  <= lock_d;
            c1_q    <= c1_d;
            c2_q    <= c2_d;
            nulo_q  <= nulo_d;
            ack_q   <= commit;
        end
    end

    seg7_digit u_seg1 (
        .digit_i (d1_q),
        .show_i  ((state_q == StOne) || (state_q == StTwo)),
        .seg_o   (entry_disp1)
    );

    seg7_digit u_seg2 (
        .digit_i (d2_q),
        .show_i  (state_q == StTwo),
        .seg_o   (entry_disp2)
    );

    assign c1       = c1_q;
    assign c2       = c2_q;
    assign nulo     = nulo_q;
    assign vote_ack = ack_q;
    assign finish   = (state_q == StClosed);

endmodule

// File: tb/tb_vote_capture.sv
// Bench for vote_capture: directed keypad sessions checked against an entry-list model every cycle.
module tb_vote_capture;

    localparam int unsigned LOCK  = 4;
    localparam int unsigned CNT_W = 8;
    localparam int          CMAX  = 255;

    logic             clock = 1'b0;
    logic             start, key_valid, confirm, correct, close_poll;
    logic [3:0]       key_digit;
    logic [6:0]       entry_disp1, entry_disp2;
    logic [CNT_W-1:0] c1, c2, nulo;
    logic             vote_ack, finish;

    always #5 clock = ~clock;

    vote_capture #(
        .LOCK_CYCLES (LOCK),
        .CNT_W       (CNT_W)
    ) dut (
        .clock       (clock),
        .start       (start),
        .key_valid   (key_valid),
        .key_digit   (key_digit),
        .confirm     (confirm),
        .correct     (correct),
        .close_poll  (close_poll),
        .entry_disp1 (entry_disp1),
        .entry_disp2 (entry_disp2),
        .c1          (c1),
        .c2          (c2),
        .nulo        (nulo),
        .vote_ack    (vote_ack),
        .finish      (finish)
    );

    int n_pass  = 0;
    int n_total = 0;
    int ack_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    endtask

    // Model: the typed digits as a list, a lock countdown, a closed flag, plain integer tallies
    logic [6:0] seg_ref [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    int m_entry[$];
    int m_lock, m_c1, m_c2, m_nulo, m_code;
    bit m_closed, m_ack;
    bit m_live = 1'b0;

    always @(posedge clock) begin
        if (start) begin
            m_entry.delete();
            m_lock = 0; m_c1 = 0; m_c2 = 0; m_nulo = 0;
            m_closed = 1'b0; m_ack = 1'b0; m_live = 1'b1;
        end else if (m_live) begin
            m_ack = 1'b0;
            if (m_closed) begin
            end else if (close_poll) begin
                m_entry.delete();
                m_lock = 0;
                m_closed = 1'b1;
            end else if (m_lock > 0) begin
                m_lock--;
            end else if (correct && m_entry.size() > 0) begin
                m_entry.delete();
            end else if (confirm && m_entry.size() == 2) begin
                m_code = m_entry[0] * 10 + m_entry[1];
                if (m_code == 13) m_c1 = (m_c1 < CMAX) ? m_c1 + 1 : CMAX;
                else if (m_code == 22) m_c2 = (m_c2 < CMAX) ? m_c2 + 1 : CMAX;
                else m_nulo = (m_nulo < CMAX) ? m_nulo + 1 : CMAX;
                m_ack = 1'b1;
                m_entry.delete();
                m_lock = LOCK;
            end else if (key_valid && key_digit <= 4'd9 && m_entry.size() < 2) begin
                m_entry.push_back(int'(key_digit));
            end
        end
    end

    always @(negedge clock) begin
        logic [6:0] e1, e2;
        if (m_live) begin
            e1 = 7'b1111111;
            e2 = 7'b1111111;
            if (m_entry.size() >= 1) e1 = seg_ref[m_entry[0]];
            if (m_entry.size() == 2) e2 = seg_ref[m_entry[1]];
            check("m_disp1", 32'(entry_disp1), 32'(e1));
            check("m_disp2", 32'(entry_disp2), 32'(e2));
            check("m_c1", 32'(c1), 32'(m_c1));
            check("m_c2", 32'(c2), 32'(m_c2));
            check("m_nulo", 32'(nulo), 32'(m_nulo));
            check("m_ack", 32'(vote_ack), 32'(m_ack));
            check("m_finish", 32'(finish), 32'(m_closed));
        end
        if (vote_ack === 1'b1) ack_cnt++;
    end

    task automatic drive(input bit kv, input logic [3:0] d, input bit cf, input bit cr,
                         input bit cp, input bit st);
        key_valid = kv; key_digit = d; confirm = cf; correct = cr; close_poll = cp; start = st;
        @(posedge clock);
        #1;
        key_valid = 1'b0; confirm = 1'b0; correct = 1'b0; close_poll = 1'b0; start = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        drive(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_confirm();
        drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_correct();
        drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_start();
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        start = 1'b1; key_valid = 1'b0; key_digit = 4'd0;
        confirm = 1'b0; correct = 1'b0; close_poll = 1'b0;
        @(posedge clock);
        do_start();
        check("rst_disp1", 32'(entry_disp1), 32'h7f);
        check("rst_c1", 32'(c1), 0);
        check("rst_ack", 32'(vote_ack), 0);
        check("rst_finish", 32'(finish), 0);

        // 1: vote 13
        press(4'd1);
        press(4'd3);
        check("t1_disp1", 32'(entry_disp1), 32'b1111001);
        check("t1_disp2", 32'(entry_disp2), 32'b0110000);
        do_confirm();
        check("t1_ack", 32'(vote_ack), 1);
        check("t1_c1", 32'(c1), 1);
        check("t1_c2", 32'(c2), 0);
        check("t1_disp_blank", 32'({entry_disp1, entry_disp2}), 32'h3fff);
        tick();
        check("t1_ack_low", 32'(vote_ack), 0);
        repeat (LOCK - 1) tick();

        // 2: vote 22, key during lock ignored, key accepted after lock
        press(4'd2);
        press(4'd2);
        do_confirm();
        press(4'd5);
        check("t2_lock_disp1", 32'(entry_disp1), 32'h7f);
        check("t2_c2", 32'(c2), 1);
        repeat (LOCK - 1) tick();
        press(4'd5);
        check("t2_disp1_5", 32'(entry_disp1), 32'b0010010);
        do_correct();

        // 3: correct, then a null vote
        do_start();
        press(4'd4);
        press(4'd7);
        check("t3_disp2_7", 32'(entry_disp2), 32'b1111000);
        do_correct();
        check("t3_cleared", 32'(entry_disp1), 32'h7f);
        press(4'd9);
        press(4'd9);
        do_confirm();
        check("t3_nulo", 32'(nulo), 1);
        check("t3_c1c2", 32'({c1, c2}), 0);
        repeat (LOCK) tick();

        // 4: early confirm ignored, confirm+correct counts nothing, invalid digit ignored
        press(4'hC);
        check("t4_bad_digit", 32'(entry_disp1), 32'h7f);
        press(4'd1);
        do_confirm();
        check("t4_early_ack", 32'(vote_ack), 0);
        check("t4_still_one", 32'(entry_disp1), 32'b1111001);
        press(4'd3);
        drive(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("t4_no_ack", 32'(vote_ack), 0);
        check("t4_counts", 32'({c1, c2, nulo}), 32'h000001);
        press(4'd8);
        check("t4_idle_key", 32'(entry_disp1), 32'b0000000);
        do_correct();

        // 5: saturation
        do_start();
        ack_cnt = 0;
        for (int i = 0; i < 260; i++) begin
            press(4'd1);
            press(4'd3);
            do_confirm();
            repeat (LOCK) tick();
        end
        check("t5_c1_sat", 32'(c1), 255);
        check("t5_acks", 32'(ack_cnt), 260);

        // 6: close poll
        do_start();
        press(4'd2);
        press(4'd2);
        do_confirm();
        repeat (LOCK) tick();
        press(4'd1);
        press(4'd3);
        check("t6_pre_finish", 32'(finish), 0);
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t6_finish", 32'(finish), 1);
        check("t6_disp_blank", 32'(entry_disp1), 32'h7f);
        check("t6_c1", 32'(c1), 0);
        press(4'd2);
        press(4'd2);
        do_confirm();
        tick();
        check("t6_frozen_c2", 32'(c2), 1);
        check("t6_still_closed", 32'(finish), 1);
        do_start();
        check("t6_reopen", 32'(finish), 0);
        check("t6_cleared", 32'({c1, c2, nulo}), 0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
